// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch sequencer for the single-issue RV32 core.
// Owns the PC, fetches over a req/ready/rvalid handshake, holds the fetched
// instruction for decode/execute until commit, then selects the next PC.
// Optional feature macro: PC_MISALIGN_TRAP_EN enables misaligned-target
// detection (TRAP state, trap pulse, epc). Without it targets are word-aligned
// by clearing bits [1:0], the TRAP state is never entered, trap/epc read 0.
module pc_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        commit,
    input  logic [1:0]  cond,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic [31:0] normal_pc,
    output logic        trap,
    output logic [31:0] epc
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        EXEC = 3'd3,
        TRAP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target;
    logic        misaligned;

    // Next-PC candidate for the instruction sitting in EXEC; only used on commit.
    always_comb begin
        target = pc_q + 32'd4;
        case (cond)
            2'b01:   target = pc_q + imm;
            2'b11:   target = {alu_out[31:1], 1'b0};
            default: target = pc_q + 32'd4;
        endcase
        misaligned = TRAP_EN && (target[1:0] != 2'b00);
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    if (misaligned) begin
                        pc_d    = TRAP_VEC;
                        epc_d   = target;
                        state_d = TRAP;
                    end else begin
                        // Low bits are already zero when trapping is enabled;
                        // otherwise this silently aligns the target.
                        pc_d    = {target[31:2], 2'b00};
                        state_d = REQ;
                    end
                end
            end
            TRAP:    state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any fetch or pending commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            inst_q  <= 32'h0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            epc_q   <= epc_d;
        end
    end

    // Moore outputs decoded from state; pc-derived outputs straight from registers.
    always_comb begin
        imem_req   = (state_q == REQ);
        inst_valid = (state_q == EXEC);
        trap       = TRAP_EN && (state_q == TRAP);
        epc        = TRAP_EN ? epc_q : 32'h0;
        imem_addr  = pc_q;
        pc         = pc_q;
        normal_pc  = pc_q + 32'd4;
        inst       = inst_q;
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl. Handles both builds of the misaligned-trap
// feature (PC_MISALIGN_TRAP_EN defined or not).
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        commit;
    logic [1:0]  cond;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic [31:0] normal_pc;
    logic        trap;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .commit      (commit),
        .cond        (cond),
        .imm         (imm),
        .alu_out     (alu_out),
        .pc          (pc),
        .normal_pc   (normal_pc),
        .trap        (trap),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: one-cycle ready, rvalid next cycle; ends in EXEC.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    // From EXEC: single-cycle commit with the given next-PC selection.
    task automatic do_commit(input logic [1:0] c, input logic [31:0] i, input logic [31:0] a);
        commit  = 1'b1;
        cond    = c;
        imm     = i;
        alu_out = a;
        tick();
        commit  = 1'b0;
        cond    = 2'b00;
        imm     = 32'h0;
        alu_out = 32'h0;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        commit = 1'b0; cond = 2'b00; imm = 32'h0; alu_out = 32'h0;

        // Reset values
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_normal_pc", normal_pc, 32'h4);

        // Release: IDLE for one cycle, then REQ
        rst = 1'b0;
        #1;
        chk("idle_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("req1_req", {31'b0, imem_req}, 32'h1);
        chk("req1_addr", imem_addr, 32'h0);

        // Sequential instruction, 3-cycle cadence
        imem_ready = 1'b1;
        tick();
        chk("resp_req", {31'b0, imem_req}, 32'h0);
        chk("resp_valid", {31'b0, inst_valid}, 32'h0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        chk("exec_valid", {31'b0, inst_valid}, 32'h1);
        chk("exec_inst", inst, 32'h0000_0013);
        chk("exec_pc", pc, 32'h0);
        do_commit(2'b00, 32'h0, 32'h0);
        chk("seq_addr", imem_addr, 32'h4);
        chk("seq_req", {31'b0, imem_req}, 32'h1);
        chk("seq_valid", {31'b0, inst_valid}, 32'h0);

        // Branch forward to 0x40, then backward by 16, then jalr with bit0 cleared
        fetch(32'h0000_0063);
        do_commit(2'b01, 32'h0000_003C, 32'h0);
        chk("br_fwd_addr", imem_addr, 32'h40);
        fetch(32'h0000_0063);
        do_commit(2'b01, 32'hFFFF_FFF0, 32'h0);
        chk("br_back_addr", imem_addr, 32'h30);
        fetch(32'h0000_0067);
        do_commit(2'b11, 32'h0, 32'h0000_1235);
        chk("jalr_addr", imem_addr, 32'h1234);
        chk("jalr_normal_pc", normal_pc, 32'h1238);

        // Stalls: ready low 3 cycles, commit outside EXEC ignored
        commit = 1'b1; cond = 2'b01; imm = 32'h8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_req", {31'b0, imem_req}, 32'h1);
            chk("stall_addr", imem_addr, 32'h1234);
        end
        commit = 1'b0; cond = 2'b00; imm = 32'h0;
        chk("stall_valid", {31'b0, inst_valid}, 32'h0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rwait_valid", {31'b0, inst_valid}, 32'h0);
            chk("rwait_req", {31'b0, imem_req}, 32'h0);
            chk("rwait_inst", inst, 32'h0000_0067);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
        tick();
        chk("late_inst", inst, 32'hAAAA_0001);
        // rvalid pulse during EXEC must not overwrite inst
        imem_rdata = 32'hBBBB_0002;
        tick();
        imem_rvalid = 1'b0;
        chk("exec_rvalid_inst", inst, 32'hAAAA_0001);
        chk("exec_rvalid_valid", {31'b0, inst_valid}, 32'h1);
        chk("exec_pc_stable", pc, 32'h1234);

        // Go to 0x10, then misaligned branch target 0x16
        do_commit(2'b11, 32'h0, 32'h0000_0010);
        chk("to10_addr", imem_addr, 32'h10);
        fetch(32'h0000_0063);
        do_commit(2'b01, 32'h0000_0006, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("trap_pulse", {31'b0, trap}, 32'h1);
        chk("trap_epc", epc, 32'h16);
        chk("trap_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("trap_end", {31'b0, trap}, 32'h0);
        chk("trap_addr", imem_addr, 32'h100);
        chk("trap_epc_held", epc, 32'h16);
`else
        chk("notrap_trap", {31'b0, trap}, 32'h0);
        chk("notrap_addr", imem_addr, 32'h14);
        chk("notrap_epc", epc, 32'h0);
        chk("notrap_req", {31'b0, imem_req}, 32'h1);
`endif

        // Wrap-around of pc+4
        fetch(32'h0000_0067);
        do_commit(2'b11, 32'h0, 32'hFFFF_FFFD);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("top_normal_pc", normal_pc, 32'h0);
        fetch(32'h0000_0013);
        do_commit(2'b00, 32'h0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_trap", {31'b0, trap}, 32'h0);

        // cond=10 behaves as sequential
        fetch(32'h0000_0013);
        do_commit(2'b10, 32'h0000_0100, 32'h0000_0200);
        chk("cond10_addr", imem_addr, 32'h4);

        // Reset pulse during RESP; rvalid after release ignored
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        #2;
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("postrst_inst", inst, 32'h0);
        chk("postrst_req", {31'b0, imem_req}, 32'h1);
        chk("postrst_addr", imem_addr, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        chk("postrst_inst2", inst, 32'h0);
        chk("postrst_valid", {31'b0, inst_valid}, 32'h0);
        chk("postrst_req2", {31'b0, imem_req}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
